// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive truth-table sweep of an N_IN-input combinational gate.
// Every input vector is driven onto the gate and held for SETTLE cycles. The gate output
// is then sampled for one cycle and compared with the expected function. The block
// reports a saturating mismatch count, the first failing vector and a pass flag.
module gate_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,  // gate input count (1..8)
    parameter int unsigned SETTLE = 2,  // hold cycles before sampling (>= 1)
    parameter int unsigned ERR_W  = 4,  // saturating mismatch counter width
    parameter int unsigned EXP_FN = 0   // 0=NAND 1=AND 2=OR 3=NOR
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_gate_y,
    output logic [N_IN-1:0]  o_gate_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [N_IN-1:0]  o_first_fail_vec,
    output logic             o_first_fail_valid
);

    // Settle timer counts 0..SETTLE-1; keep at least one bit when SETTLE is 1.
    localparam int unsigned      TMR_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_d;

    logic [TMR_W-1:0] r_timer;
    logic [N_IN-1:0]  r_gate_in;
    logic [ERR_W-1:0] r_err_cnt;
    logic [N_IN-1:0]  r_ff_vec;
    logic             r_ff_valid;
    logic             r_pass;

    // Control strobes decoded from the FSM.
    logic             w_sweep_start;
    logic             w_tmr_inc;
    logic             w_sample;
    logic             w_finish;

    logic             w_last_vec;
    logic             w_exp_y;
    logic             w_mismatch;

    assign w_last_vec = (r_gate_in == {N_IN{1'b1}});
    assign w_mismatch = (i_gate_y != w_exp_y);

    // Expected gate output for the vector currently applied.
    always_comb begin
        w_exp_y = 1'b0;
        case (EXP_FN)
            0:       w_exp_y = ~(&r_gate_in);
            1:       w_exp_y = &r_gate_in;
            2:       w_exp_y = |r_gate_in;
            default: w_exp_y = ~(|r_gate_in);
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        w_state_d     = r_state;
        w_sweep_start = 1'b0;
        w_tmr_inc     = 1'b0;
        w_sample      = 1'b0;
        w_finish      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_sweep_start = 1'b1;
                    w_state_d     = StSettle;
                end
            end
            StSettle: begin
                if (r_timer == TMR_LAST) begin
                    w_state_d = StSample;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            StSample: begin
                w_sample  = 1'b1;
                w_state_d = w_last_vec ? StDone : StSettle;
            end
            StDone: begin
                w_finish  = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Settle timer: restarted for every vector, advances while settling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (w_sweep_start || w_sample) begin
            r_timer <= '0;
        end else if (w_tmr_inc) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Vector counter doubles as the gate drive; it holds its last value once idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gate_in <= '0;
        end else if (w_sweep_start) begin
            r_gate_in <= '0;
        end else if (w_sample && !w_last_vec) begin
            r_gate_in <= r_gate_in + 1'b1;
        end
    end

    // Saturating mismatch counter; saturation never cuts the sweep short.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (w_sweep_start) begin
            r_err_cnt <= '0;
        end else if (w_sample && w_mismatch && (r_err_cnt != ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    // First-failure capture: only the earliest mismatching vector is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
        end else if (w_sweep_start) begin
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
        end else if (w_sample && w_mismatch && !r_ff_valid) begin
            r_ff_vec   <= r_gate_in;
            r_ff_valid <= 1'b1;
        end
    end

    // Pass flag is cleared on start and resolved as the DONE cycle ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass <= 1'b0;
        end else if (w_sweep_start) begin
            r_pass <= 1'b0;
        end else if (w_finish) begin
            r_pass <= (r_err_cnt == '0);
        end
    end

    assign o_gate_in          = r_gate_in;
    assign o_busy             = (r_state != StIdle);
    assign o_done             = (r_state == StDone);
    assign o_pass             = r_pass;
    assign o_err_cnt          = r_err_cnt;
    assign o_first_fail_vec   = r_ff_vec;
    assign o_first_fail_valid = r_ff_valid;

endmodule
